// File: rtl/memory_port_master_pkg.sv
// -----------------------------------------------------------------------------
// memory_port_master_pkg
//   Shared definitions for the memory port master and its read buffer.
//   Holds the FSM state encoding only; the memory-port widths (WORD_SIZE,
//   ADDR_SIZE) stay module parameters so they always follow the attached Memory.
// -----------------------------------------------------------------------------
package memory_port_master_pkg;

    // Burst sequencer states.
    //   ST_IDLE  : waiting for a command, cmd_ready high
    //   ST_WRITE : streaming wr_data into consecutive addresses
    //   ST_READ  : streaming consecutive addresses out through the read buffer
    //   ST_DONE  : single completion cycle, done high
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/memory_port_master_mem_rd_buffer.sv
// -----------------------------------------------------------------------------
// mem_rd_buffer
//   One-entry valid/ready output register for read data.
//   load has priority: it captures din and sets valid. Without a load, a
//   consumed word (valid && ready) clears valid. Otherwise data and valid hold,
//   so data stays stable while the consumer stalls.
//
// Ports
//   clock  : clock, posedge
//   reset  : asynchronous active-high reset, clears valid and data
//   load   : capture din this edge
//   ready  : consumer accepts data this cycle
//   din    : incoming word (memory read data)
//   valid  : register holds a word
//   data   : held word
// -----------------------------------------------------------------------------
module mem_rd_buffer #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 ready,
    input  logic [WORD_SIZE-1:0] din,
    output logic                 valid,
    output logic [WORD_SIZE-1:0] data
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_port_master.sv
// -----------------------------------------------------------------------------
// memory_port_master
//   Initiator for a Memory port (wen/addr/wdata/rdata). Takes a burst command
//   (direction, base address, word count minus one) and either writes a
//   valid/ready stream into consecutive addresses or reads consecutive
//   addresses out into a valid/ready stream, one word per cycle. Addresses
//   wrap modulo 2**ADDR_SIZE.
//
// Ports
//   clock, reset          : clock and asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake, cmd_ready high only in IDLE
//   cmd_write             : 1 = write burst, 0 = read burst
//   cmd_base, cmd_count   : first address, burst length minus one
//   wr_valid/wr_ready     : write-data stream in (wr_ready high in WRITE)
//   wr_data               : write-data word
//   rd_valid/rd_ready     : read-data stream out (registered)
//   rd_data               : read-data word
//   busy                  : not idle
//   done                  : one-cycle pulse at burst completion
//   mem_wen, mem_addr,
//   mem_wdata             : to the Memory
//   mem_rdata             : from the Memory, combinational read of mem_addr
// -----------------------------------------------------------------------------
module memory_port_master
    import memory_port_master_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_SIZE-1:0] cmd_base,
    input  logic [ADDR_SIZE-1:0] cmd_count,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    state_t                 state;
    logic [ADDR_SIZE-1:0]   cur_addr;
    logic [ADDR_SIZE-1:0]   remaining;
    // Read bursts only: words still to be fetched from memory. Cleared when
    // the last address is loaded; the burst then ends when that word drains.
    logic                   issue_pending;

    logic                   wr_fire;
    logic                   rd_load;
    logic                   rd_take;
    logic                   buf_valid;
    logic [WORD_SIZE-1:0]   buf_data;

    // Status decodes straight from the state register.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign wr_ready  = (state == ST_WRITE);

    // The write strobe follows wr_valid combinationally, so an async reset
    // (which forces IDLE) removes it within the same cycle.
    assign wr_fire   = wr_ready && wr_valid;
    assign mem_wen   = wr_fire;
    assign mem_addr  = cur_addr;
    assign mem_wdata = wr_data;

    // Fetch the next word whenever the output register is empty or being
    // emptied this cycle; this keeps one word per cycle with rd_ready high.
    assign rd_load   = (state == ST_READ) && issue_pending && (!buf_valid || rd_ready);
    assign rd_take   = buf_valid && rd_ready;

    mem_rd_buffer #(
        .WORD_SIZE (WORD_SIZE)
    ) u_rd_buffer (
        .clock (clock),
        .reset (reset),
        .load  (rd_load),
        .ready (rd_ready),
        .din   (mem_rdata),
        .valid (buf_valid),
        .data  (buf_data)
    );

    // The buffer is only ever filled in READ and drains before leaving it,
    // so its valid is already low in every other state.
    assign rd_valid = buf_valid;
    assign rd_data  = buf_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            issue_pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr      <= cmd_base;
                        remaining     <= cmd_count;
                        issue_pending <= !cmd_write;
                        state         <= cmd_write ? ST_WRITE : ST_READ;
                    end
                end

                ST_WRITE: begin
                    if (wr_fire) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == '0) begin
                            state <= ST_DONE;
                        end
                    end
                end

                ST_READ: begin
                    if (rd_load) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == '0) begin
                            issue_pending <= 1'b0;
                        end
                    end
                    // A take with nothing left to fetch is the final word.
                    if (rd_take && !issue_pending) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_master.sv
module tb_memory_port_master;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_base, cmd_count;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy, done, mem_wen;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Attached memory: combinational read, write on posedge.
    logic [7:0] mem [256];
    // Expected memory contents, maintained from the burst rules alone.
    logic [7:0] ref_mem [256];
    // Current burst plan: data words and the address each must land at.
    logic [7:0] wq [$];
    logic [7:0] aq [$];

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clock) if (mem_wen === 1'b1) mem[mem_addr] <= mem_wdata;
    always @(negedge clock) if (done === 1'b1) done_cnt++;

    memory_port_master #(.WORD_SIZE(8), .ADDR_SIZE(8)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Build a burst plan of n words starting at base (addresses wrap at 256).
    task automatic plan(input logic [7:0] base, input int n, input bit rnd);
        wq.delete();
        aq.delete();
        for (int i = 0; i < n; i++) begin
            aq.push_back(8'(int'(base) + i));
            wq.push_back(rnd ? 8'($urandom) : 8'(i * 7 + 3));
        end
    endtask

    task automatic issue(input logic w, input logic [7:0] b, input logic [7:0] c);
        int n;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = w; cmd_base = b; cmd_count = c;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clock); #1; n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        @(posedge clock); #1;
        // Scramble the fields: the burst must use the values latched at acceptance.
        cmd_valid = 1'b0; cmd_base = 8'($urandom); cmd_count = 8'($urandom);
        cmd_write = 1'($urandom);
    endtask

    // mode 0: back-to-back, 1: alternate 1,0,1,0..., 2: random gaps
    task automatic write_phase(input int mode);
        int idx, cyc, d0;
        idx = 0; cyc = 0; d0 = done_cnt;
        while (idx < wq.size() && cyc < 4000) begin
            @(negedge clock);
            case (mode)
                0:       wr_valid = 1'b1;
                1:       wr_valid = (cyc % 2 == 0);
                default: wr_valid = ($urandom_range(0, 2) != 0);
            endcase
            wr_data = wr_valid ? wq[idx] : 8'($urandom);
            #1;
            check("wr_ready", wr_ready, 1'b1);
            check("wr_mem_wen", mem_wen, wr_valid);
            check("wr_done_low", done, 1'b0);
            if (wr_valid) begin
                check("wr_addr", mem_addr, aq[idx]);
                check("wr_wdata", mem_wdata, wq[idx]);
                ref_mem[aq[idx]] = wq[idx];
                idx++;
            end
            cyc++;
        end
        check("wr_words_written", idx, wq.size());
        if (mode == 0) check("wr_throughput_cycles", cyc, wq.size());
        @(negedge clock);
        wr_valid = 1'b0;
        #1;
        check("wr_done_pulse", done, 1'b1);
        check("wr_done_busy", busy, 1'b1);
        check("wr_done_no_wen", mem_wen, 1'b0);
        @(negedge clock); #1;
        check("wr_done_once", done, 1'b0);
        check("wr_idle_ready", cmd_ready, 1'b1);
        check("wr_idle_busy", busy, 1'b0);
        check("wr_done_count", done_cnt - d0, 1);
    endtask

    // mode 0: rd_ready always, 1: pattern 1,0,0 repeating, 2: random
    task automatic read_phase(input int mode);
        int got, cyc, d0;
        logic stalled;
        logic [7:0] held;
        got = 0; cyc = 0; d0 = done_cnt; stalled = 1'b0; held = '0;
        while (got < aq.size() && cyc < 4000) begin
            @(negedge clock);
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 3 == 0);
                default: rd_ready = 1'($urandom);
            endcase
            wr_valid = 1'b1;  // must be ignored outside WRITE
            wr_data  = 8'($urandom);
            #1;
            check("rd_mem_wen", mem_wen, 1'b0);
            check("rd_wr_ready", wr_ready, 1'b0);
            if (cyc == 0) check("rd_latency_first_cycle", rd_valid, 1'b0);
            if (cyc == 1) check("rd_latency_second_cycle", rd_valid, 1'b1);
            if (stalled) begin
                check("rd_hold_valid", rd_valid, 1'b1);
                check("rd_hold_data", rd_data, held);
            end
            if (rd_valid && rd_ready) begin
                check("rd_data", rd_data, ref_mem[aq[got]]);
                got++;
            end
            stalled = rd_valid && !rd_ready;
            held = rd_data;
            cyc++;
        end
        check("rd_words_read", got, aq.size());
        if (mode == 0) check("rd_throughput_cycles", cyc, aq.size() + 1);
        @(negedge clock);
        rd_ready = 1'b0; wr_valid = 1'b0;
        #1;
        check("rd_done_pulse", done, 1'b1);
        check("rd_done_valid_low", rd_valid, 1'b0);
        @(negedge clock); #1;
        check("rd_done_once", done, 1'b0);
        check("rd_idle_ready", cmd_ready, 1'b1);
        check("rd_done_count", done_cnt - d0, 1);
    endtask

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  count;
        logic [31:0] words;   // word i in bits [8*i+7:8*i]
        logic [31:0] addrs;   // expected write address of word i
        int          rmode;
    } wvec_t;

    wvec_t tbl [3];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i ^ 8'h5A);
            ref_mem[i] = 8'(i ^ 8'h5A);
        end
        cmd_valid = 0; cmd_write = 0; cmd_base = 0; cmd_count = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        reset = 1'b1;

        // Reset state
        #2;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_wr_ready", wr_ready, 1'b0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        // Table-driven write bursts followed by read-back.
        tbl[0] = '{8'h10, 8'd3, 32'hA4A3A2A1, 32'h13121110, 0};
        tbl[1] = '{8'hFE, 8'd3, 32'hC4C3C2C1, 32'h0100FFFE, 0};
        tbl[2] = '{8'h40, 8'd1, 32'h0000B2B1, 32'h00004140, 1};
        for (int t = 0; t < 3; t++) begin
            wq.delete(); aq.delete();
            for (int i = 0; i <= int'(tbl[t].count); i++) begin
                wq.push_back(tbl[t].words[8*i +: 8]);
                aq.push_back(tbl[t].addrs[8*i +: 8]);
            end
            issue(1'b1, tbl[t].base, tbl[t].count);
            write_phase(0);
            for (int i = 0; i < wq.size(); i++) check("tbl_mem_contents", mem[aq[i]], wq[i]);
            issue(1'b0, tbl[t].base, tbl[t].count);
            read_phase(tbl[t].rmode);
        end

        // Read backpressure on the first burst: 1,0,0 ready pattern.
        wq.delete(); aq.delete();
        for (int i = 0; i < 4; i++) aq.push_back(8'(8'h10 + i));
        issue(1'b0, 8'h10, 8'd3);
        read_phase(1);

        // Write stall: alternating wr_valid, count 2.
        plan(8'h30, 3, 1'b0);
        issue(1'b1, 8'h30, 8'd2);
        write_phase(1);
        check("stall_untouched_next", mem[8'h33], ref_mem[8'h33]);

        // Command offered during DONE is held off until the following IDLE.
        plan(8'h50, 1, 1'b0);
        issue(1'b1, 8'h50, 8'd0);
        @(negedge clock); wr_valid = 1'b1; wr_data = 8'h77; #1;
        check("dn_last_write", mem_wen, 1'b1);
        @(negedge clock);
        wr_valid = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 8'h50; cmd_count = 8'd0;
        #1;
        check("dn_done", done, 1'b1);
        check("dn_not_ready", cmd_ready, 1'b0);
        @(negedge clock); #1;
        check("dn_idle_ready", cmd_ready, 1'b1);
        check("dn_idle_busy", busy, 1'b0);
        @(negedge clock); cmd_valid = 1'b0; rd_ready = 1'b1; #1;
        check("dn_read_busy", busy, 1'b1);
        check("dn_read_empty", rd_valid, 1'b0);
        @(negedge clock); #1;
        check("dn_read_valid", rd_valid, 1'b1);
        check("dn_read_data", rd_data, 8'h77);
        @(negedge clock); rd_ready = 1'b0; #1;
        check("dn_read_done", done, 1'b1);
        ref_mem[8'h50] = 8'h77;
        @(negedge clock);

        // Reset after the 2nd of 4 writes.
        issue(1'b1, 8'h60, 8'd3);
        @(negedge clock); wr_valid = 1'b1; wr_data = 8'hD1;
        @(negedge clock); wr_valid = 1'b1; wr_data = 8'hD2;
        @(negedge clock); wr_valid = 1'b1; wr_data = 8'hD3; #1;
        check("rs_wen_before", mem_wen, 1'b1);
        d0 = done_cnt;
        reset = 1'b1; #1;
        check("rs_wen_drop", mem_wen, 1'b0);
        check("rs_busy", busy, 1'b0);
        check("rs_done", done, 1'b0);
        @(negedge clock); reset = 1'b0; wr_valid = 1'b0; #1;
        check("rs_cmd_ready", cmd_ready, 1'b1);
        @(negedge clock); #1;
        check("rs_no_done", done_cnt - d0, 0);
        check("rs_mem60", mem[8'h60], 8'hD1);
        check("rs_mem61", mem[8'h61], 8'hD2);
        check("rs_mem62", mem[8'h62], ref_mem[8'h62]);
        check("rs_mem63", mem[8'h63], ref_mem[8'h63]);
        ref_mem[8'h60] = 8'hD1; ref_mem[8'h61] = 8'hD2;

        // Reset with a stalled read word discards it.
        issue(1'b0, 8'h10, 8'd3);
        rd_ready = 1'b0;
        @(negedge clock); @(negedge clock); #1;
        check("rsr_held", rd_valid, 1'b1);
        reset = 1'b1; #1;
        check("rsr_valid", rd_valid, 1'b0);
        check("rsr_data", rd_data, 8'h00);
        @(negedge clock); reset = 1'b0;

        // Whole memory in one burst, wrapping from 0x80.
        plan(8'h80, 256, 1'b1);
        issue(1'b1, 8'h80, 8'hFF);
        write_phase(2);
        issue(1'b0, 8'h80, 8'hFF);
        read_phase(2);

        // Random bursts.
        for (int r = 0; r < 16; r++) begin
            logic [7:0] b;
            int n;
            b = 8'($urandom);
            n = $urandom_range(1, 12);
            plan(b, n, 1'b1);
            issue(1'b1, b, 8'(n - 1));
            write_phase(2);
            issue(1'b0, b, 8'(n - 1));
            read_phase(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
